// File: rtl/vanilla_instr_encoder_pkg.sv
// Shared types, opcode/function constants and field-packing helpers for the
// vanilla instruction encoder.
package vanilla_instr_encoder_pkg;

    // RV32 major opcodes
    localparam logic [6:0] RV32_LOAD     = 7'b0000011;
    localparam logic [6:0] RV32_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] RV32_MISC_MEM = 7'b0001111;
    localparam logic [6:0] RV32_OP_IMM   = 7'b0010011;
    localparam logic [6:0] RV32_STORE    = 7'b0100011;
    localparam logic [6:0] RV32_STORE_FP = 7'b0100111;
    localparam logic [6:0] RV32_AMO_OP   = 7'b0101111;
    localparam logic [6:0] RV32_OP       = 7'b0110011;
    localparam logic [6:0] RV32_LUI      = 7'b0110111;
    localparam logic [6:0] RV32_OP_FP    = 7'b1010011;

    // Function-field constants
    localparam logic [2:0] FUNCT3_ADD    = 3'b000;
    localparam logic [2:0] FUNCT3_WORD   = 3'b010;
    localparam logic [2:0] FUNCT3_RM_RNE = 3'b000;
    localparam logic [6:0] FUNCT7_ADD    = 7'b0000000;
    localparam logic [6:0] FUNCT7_FADD_S = 7'b0000000;
    localparam logic [4:0] FUNCT5_AMOADD = 5'b00000;

    // FENCE iorw,iorw
    localparam logic [31:0] FENCE_INSTR  = 32'h0FF0000F;

    // Expansion FSM encodings
    localparam logic [0:0] eIdle = 1'b0;
    localparam logic [0:0] eLiLo = 1'b1;

    typedef enum logic [3:0] {
        eENC_ADD      = 4'd0,
        eENC_ADDI     = 4'd1,
        eENC_LW       = 4'd2,
        eENC_SW       = 4'd3,
        eENC_FLW      = 4'd4,
        eENC_FSW      = 4'd5,
        eENC_FADD_S   = 4'd6,
        eENC_AMOADD_W = 4'd7,
        eENC_FENCE    = 4'd8,
        eENC_LI       = 4'd9
    } enc_op_e;

    typedef struct packed {
        enc_op_e     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        aq;
        logic        rl;
    } enc_cmd_s;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] op;
    } instruction_s;

    // True when a 32-bit value is representable as a signed 12-bit immediate
    function automatic logic fits_simm12(input logic [31:0] v);
        return (v[31:11] == '0) || (v[31:11] == '1);
    endfunction

    function automatic instruction_s enc_r_type(input logic [6:0] f7,
                                                input logic [4:0] rs2,
                                                input logic [4:0] rs1,
                                                input logic [2:0] f3,
                                                input logic [4:0] rd,
                                                input logic [6:0] op);
        instruction_s r;
        r.funct7 = f7;
        r.rs2    = rs2;
        r.rs1    = rs1;
        r.funct3 = f3;
        r.rd     = rd;
        r.op     = op;
        return r;
    endfunction

    function automatic instruction_s enc_i_type(input logic [11:0] imm,
                                                input logic [4:0]  rs1,
                                                input logic [2:0]  f3,
                                                input logic [4:0]  rd,
                                                input logic [6:0]  op);
        instruction_s r;
        r.funct7 = imm[11:5];
        r.rs2    = imm[4:0];
        r.rs1    = rs1;
        r.funct3 = f3;
        r.rd     = rd;
        r.op     = op;
        return r;
    endfunction

    function automatic instruction_s enc_s_type(input logic [11:0] imm,
                                                input logic [4:0]  rs2,
                                                input logic [4:0]  rs1,
                                                input logic [2:0]  f3,
                                                input logic [6:0]  op);
        instruction_s r;
        r.funct7 = imm[11:5];
        r.rs2    = rs2;
        r.rs1    = rs1;
        r.funct3 = f3;
        r.rd     = imm[4:0];
        r.op     = op;
        return r;
    endfunction

    function automatic instruction_s enc_u_type(input logic [19:0] imm,
                                                input logic [4:0]  rd,
                                                input logic [6:0]  op);
        instruction_s r;
        r.funct7 = imm[19:13];
        r.rs2    = imm[12:8];
        r.rs1    = imm[7:3];
        r.funct3 = imm[2:0];
        r.rd     = rd;
        r.op     = op;
        return r;
    endfunction

endpackage

// File: rtl/vanilla_instr_encode_comb.sv
// Combinational encoder: one command (plus LI hi/lo select) to one RV32 word,
// with flags for a two-word LI expansion and an out-of-range immediate.
module vanilla_instr_encode_comb
    import vanilla_instr_encoder_pkg::*;
(
    input  enc_cmd_s     cmd_i,
    input  logic         sel_lo_i,
    output instruction_s instr_o,
    output logic         two_word_o,
    output logic         illegal_o
);

    logic        fits;
    logic [19:0] hi_part;

    assign fits = fits_simm12(cmd_i.imm);

    // (imm + 0x800) >> 12 mod 2^32: the +0x800 only carries into bit 12 when imm[11] is set
    assign hi_part = cmd_i.imm[31:12] + {19'b0, cmd_i.imm[11]};

    // Select the encoding for the requested operation
    always_comb begin
        instr_o    = '0;
        two_word_o = 1'b0;
        illegal_o  = 1'b0;
        case (cmd_i.op)
            eENC_ADD: begin
                instr_o = enc_r_type(FUNCT7_ADD, cmd_i.rs2, cmd_i.rs1, FUNCT3_ADD,
                                     cmd_i.rd, RV32_OP);
            end
            eENC_ADDI: begin
                instr_o   = enc_i_type(cmd_i.imm[11:0], cmd_i.rs1, FUNCT3_ADD,
                                       cmd_i.rd, RV32_OP_IMM);
                illegal_o = ~fits;
            end
            eENC_LW: begin
                instr_o   = enc_i_type(cmd_i.imm[11:0], cmd_i.rs1, FUNCT3_WORD,
                                       cmd_i.rd, RV32_LOAD);
                illegal_o = ~fits;
            end
            eENC_FLW: begin
                instr_o   = enc_i_type(cmd_i.imm[11:0], cmd_i.rs1, FUNCT3_WORD,
                                       cmd_i.rd, RV32_LOAD_FP);
                illegal_o = ~fits;
            end
            eENC_SW: begin
                instr_o   = enc_s_type(cmd_i.imm[11:0], cmd_i.rs2, cmd_i.rs1,
                                       FUNCT3_WORD, RV32_STORE);
                illegal_o = ~fits;
            end
            eENC_FSW: begin
                instr_o   = enc_s_type(cmd_i.imm[11:0], cmd_i.rs2, cmd_i.rs1,
                                       FUNCT3_WORD, RV32_STORE_FP);
                illegal_o = ~fits;
            end
            eENC_FADD_S: begin
                instr_o = enc_r_type(FUNCT7_FADD_S, cmd_i.rs2, cmd_i.rs1, FUNCT3_RM_RNE,
                                     cmd_i.rd, RV32_OP_FP);
            end
            eENC_AMOADD_W: begin
                instr_o = enc_r_type({FUNCT5_AMOADD, cmd_i.aq, cmd_i.rl}, cmd_i.rs2,
                                     cmd_i.rs1, FUNCT3_WORD, cmd_i.rd, RV32_AMO_OP);
            end
            eENC_FENCE: begin
                instr_o = FENCE_INSTR;
            end
            eENC_LI: begin
                // A large imm stays large in the pending copy, so fits is still false on the lo pass
                if (fits) begin
                    instr_o = enc_i_type(cmd_i.imm[11:0], 5'd0, FUNCT3_ADD,
                                         cmd_i.rd, RV32_OP_IMM);
                end else if (sel_lo_i) begin
                    instr_o = enc_i_type(cmd_i.imm[11:0], cmd_i.rd, FUNCT3_ADD,
                                         cmd_i.rd, RV32_OP_IMM);
                end else begin
                    instr_o = enc_u_type(hi_part, cmd_i.rd, RV32_LUI);
                end
                two_word_o = ~fits & (cmd_i.imm[11:0] != 12'd0);
            end
            default: begin
                instr_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/vanilla_instr_encoder.sv
// Command-to-instruction encoder with LI expansion and a one-entry
// valid/yumi output register.
//
//  state | meaning
//  eIdle | no expansion pending; new commands may be accepted
//  eLiLo | LUI held in the output register, ADDI low part pending
module vanilla_instr_encoder
    import vanilla_instr_encoder_pkg::*;
#(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 5
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         v_i,
    input  enc_cmd_s     cmd_i,
    output logic         ready_o,
    output logic         v_o,
    output instruction_s instr_o,
    input  logic         yumi_i,
    output logic         illegal_o
);

    logic [0:0]                  state_q, state_d;
    logic                        v_q, v_d;
    instruction_s                instr_q, instr_d;
    logic                        illegal_q, illegal_d;
    logic [reg_addr_width_p-1:0] pend_rd_q, pend_rd_d;
    logic [data_width_p-1:0]     pend_imm_q, pend_imm_d;

    enc_cmd_s     enc_cmd;
    logic         enc_sel_lo;
    instruction_s enc_instr;
    logic         enc_two_word;
    logic         enc_illegal;
    logic         accept;

    assign ready_o = (state_q == eIdle) & (~v_q | yumi_i);
    assign accept  = v_i & ready_o;

    // Feed the encoder either the incoming command or the pending LI low part
    always_comb begin
        enc_cmd    = cmd_i;
        enc_sel_lo = 1'b0;
        if (state_q == eLiLo) begin
            enc_cmd     = '0;
            enc_cmd.op  = eENC_LI;
            enc_cmd.rd  = pend_rd_q;
            enc_cmd.imm = pend_imm_q;
            enc_sel_lo  = 1'b1;
        end
    end

    vanilla_instr_encode_comb u_encode (
        .cmd_i      (enc_cmd),
        .sel_lo_i   (enc_sel_lo),
        .instr_o    (enc_instr),
        .two_word_o (enc_two_word),
        .illegal_o  (enc_illegal)
    );

    // Next-state for the FSM, the output register and the pending LI fields
    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        instr_d    = instr_q;
        pend_rd_d  = pend_rd_q;
        pend_imm_d = pend_imm_q;
        illegal_d  = accept & enc_illegal;
        if (state_q == eLiLo) begin
            if (yumi_i) begin
                instr_d = enc_instr;
                v_d     = 1'b1;
                state_d = eIdle;
            end
        end else if (accept & ~enc_illegal) begin
            instr_d = enc_instr;
            v_d     = 1'b1;
            if (enc_two_word) begin
                state_d    = eLiLo;
                pend_rd_d  = cmd_i.rd;
                pend_imm_d = cmd_i.imm;
            end
        end else if (yumi_i) begin
            // Covers a dropped illegal command too: the old word still leaves on yumi
            v_d = 1'b0;
        end
    end

    // State and output register update with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= eIdle;
            v_q        <= 1'b0;
            instr_q    <= '0;
            illegal_q  <= 1'b0;
            pend_rd_q  <= '0;
            pend_imm_q <= '0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            instr_q    <= instr_d;
            illegal_q  <= illegal_d;
            pend_rd_q  <= pend_rd_d;
            pend_imm_q <= pend_imm_d;
        end
    end

    assign v_o       = v_q;
    assign instr_o   = instr_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_vanilla_instr_encoder.sv
// Self-checking bench for vanilla_instr_encoder: expected words are queued
// when commands are driven and compared as the DUT presents them.
module tb_vanilla_instr_encoder;
    import vanilla_instr_encoder_pkg::*;

    logic         clk;
    logic         reset_i;
    logic         v_i;
    enc_cmd_s     cmd_i;
    logic         ready_o;
    logic         v_o;
    instruction_s instr_o;
    logic         yumi_i;
    logic         illegal_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expq[$];
    logic [31:0] exp_w;

    vanilla_instr_encoder #(.data_width_p(32), .reg_addr_width_p(5)) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .v_i       (v_i),
        .cmd_i     (cmd_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .instr_o   (instr_o),
        .yumi_i    (yumi_i),
        .illegal_o (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic enc_cmd_s mk(input enc_op_e op, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [31:0] imm, input logic aq, input logic rl);
        enc_cmd_s c;
        c.op = op; c.rd = rd; c.rs1 = rs1; c.rs2 = rs2; c.imm = imm; c.aq = aq; c.rl = rl;
        return c;
    endfunction

    function automatic logic [31:0] m_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] m_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    function automatic logic [31:0] m_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    task automatic test_reset();
        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
        cmd_i = mk(eENC_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) tick();
        reset_i = 1'b0;
        @(negedge clk);
        checks++;
        if (v_o !== 1'b0 || illegal_o !== 1'b0 || instr_o !== 32'h0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset: v_o=%b illegal_o=%b instr_o=%h ready_o=%b, required 0 0 00000000 1",
                     v_o, illegal_o, instr_o, ready_o);
        end
        tick();
    endtask

    task automatic test_stream();
        enc_cmd_s    cmds[12];
        logic [31:0] exps[12];
        cmds[0]  = mk(eENC_ADDI,     5'd5, 5'd0, 5'd0, 32'd5, 1'b0, 1'b0);   exps[0]  = 32'h00500293;
        cmds[1]  = mk(eENC_ADD,      5'd1, 5'd2, 5'd3, 32'hDEAD, 1'b0, 1'b0); exps[1] = m_r(7'd0, 5'd3, 5'd2, 3'b000, 5'd1, 7'h33);
        cmds[2]  = mk(eENC_LW,       5'd4, 5'd2, 5'd0, -32'sd4, 1'b0, 1'b0);  exps[2]  = m_i(12'hFFC, 5'd2, 3'b010, 5'd4, 7'h03);
        cmds[3]  = mk(eENC_SW,       5'd0, 5'd2, 5'd4, 32'd100, 1'b0, 1'b0);  exps[3]  = m_s(12'd100, 5'd4, 5'd2, 3'b010, 7'h23);
        cmds[4]  = mk(eENC_FLW,      5'd3, 5'd1, 5'd0, 32'd8, 1'b0, 1'b0);    exps[4]  = m_i(12'd8, 5'd1, 3'b010, 5'd3, 7'h07);
        cmds[5]  = mk(eENC_FSW,      5'd0, 5'd1, 5'd3, -32'sd8, 1'b0, 1'b0);  exps[5]  = m_s(12'hFF8, 5'd3, 5'd1, 3'b010, 7'h27);
        cmds[6]  = mk(eENC_FADD_S,   5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0);    exps[6]  = m_r(7'd0, 5'd3, 5'd2, 3'b000, 5'd1, 7'h53);
        cmds[7]  = mk(eENC_AMOADD_W, 5'd1, 5'd3, 5'd2, 32'd0, 1'b0, 1'b0);    exps[7]  = 32'h0021A0AF;
        cmds[8]  = mk(eENC_AMOADD_W, 5'd1, 5'd3, 5'd2, 32'd0, 1'b1, 1'b1);    exps[8]  = 32'h0621A0AF;
        cmds[9]  = mk(eENC_FENCE,    5'd9, 5'd7, 5'd6, 32'h1234, 1'b1, 1'b0); exps[9]  = 32'h0FF0000F;
        cmds[10] = mk(eENC_ADDI,     5'd7, 5'd1, 5'd0, 32'd2047, 1'b0, 1'b0); exps[10] = m_i(12'h7FF, 5'd1, 3'b000, 5'd7, 7'h13);
        cmds[11] = mk(eENC_ADDI,     5'd8, 5'd0, 5'd0, -32'sd2048, 1'b0, 1'b0); exps[11] = 32'h80000413;
        for (int i = 0; i < 12; i++) begin
            cmd_i = cmds[i]; v_i = 1'b1; yumi_i = (i > 0);
            expq.push_back(exps[i]);
            @(negedge clk);
            if (i > 0) begin
                exp_w = expq.pop_front();
                checks++;
                if (v_o !== 1'b1 || instr_o !== exp_w) begin
                    errors++;
                    $display("FAIL stream[%0d]: v_o=%b instr_o=%h, required 1 %h", i - 1, v_o, instr_o, exp_w);
                end
            end
            checks++;
            if (ready_o !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d]: ready_o=%b, required 1", i, ready_o);
            end
            tick();
        end
        v_i = 1'b0; yumi_i = 1'b1;
        @(negedge clk);
        exp_w = expq.pop_front();
        checks++;
        if (v_o !== 1'b1 || instr_o !== exp_w) begin
            errors++;
            $display("FAIL stream_last: v_o=%b instr_o=%h, required 1 %h", v_o, instr_o, exp_w);
        end
        tick();
        yumi_i = 1'b0;
        @(negedge clk);
        checks++;
        if (v_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_empty: v_o=%b, required 0", v_o);
        end
        tick();
    endtask

    task automatic test_li_two(input logic [31:0] imm, input logic [31:0] lui, input logic [31:0] addi);
        cmd_i = mk(eENC_LI, 5'd5, 5'd0, 5'd0, imm, 1'b0, 1'b0);
        v_i = 1'b1; yumi_i = 1'b0;
        expq.push_back(lui); expq.push_back(addi);
        tick();
        v_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++;
            if (v_o !== 1'b1 || instr_o !== expq[0] || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL li_lui_stall imm=%h: v_o=%b instr_o=%h ready_o=%b, required 1 %h 0",
                         imm, v_o, instr_o, ready_o, expq[0]);
            end
            tick();
        end
        yumi_i = 1'b1;
        @(negedge clk);
        exp_w = expq.pop_front();
        checks++;
        if (v_o !== 1'b1 || instr_o !== exp_w || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL li_lui imm=%h: v_o=%b instr_o=%h ready_o=%b, required 1 %h 0",
                     imm, v_o, instr_o, ready_o, exp_w);
        end
        tick();
        @(negedge clk);
        exp_w = expq.pop_front();
        checks++;
        if (v_o !== 1'b1 || instr_o !== exp_w || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL li_addi imm=%h: v_o=%b instr_o=%h ready_o=%b, required 1 %h 1",
                     imm, v_o, instr_o, ready_o, exp_w);
        end
        tick();
        yumi_i = 1'b0;
        @(negedge clk);
        checks++;
        if (v_o !== 1'b0) begin
            errors++;
            $display("FAIL li_done imm=%h: v_o=%b, required 0", imm, v_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] names[3];
        cmd_i = mk(eENC_LI, 5'd5, 5'd0, 5'd0, 32'h1000, 1'b0, 1'b0);
        v_i = 1'b1; yumi_i = 1'b0;
        expq.push_back(32'h000012B7);
        tick();
        cmd_i = mk(eENC_FENCE, 5'd3, 5'd3, 5'd3, 32'hFFFF, 1'b1, 1'b1);
        yumi_i = 1'b1;
        expq.push_back(32'h0FF0000F);
        @(negedge clk);
        exp_w = expq.pop_front();
        checks++;
        if (v_o !== 1'b1 || instr_o !== exp_w || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_li_single: v_o=%b instr_o=%h ready_o=%b, required 1 %h 1",
                     v_o, instr_o, ready_o, exp_w);
        end
        tick();
        cmd_i = mk(eENC_LI, 5'd5, 5'd0, 5'd0, -32'sd5, 1'b0, 1'b0);
        expq.push_back(32'hFFB00293);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_w = expq.pop_front();
            checks++;
            if (v_o !== 1'b1 || instr_o !== exp_w) begin
                errors++;
                $display("FAIL b2b_word[%0d]: v_o=%b instr_o=%h, required 1 %h", i, v_o, instr_o, exp_w);
            end
            tick();
            v_i = 1'b0;
        end
        yumi_i = 1'b0;
        names[0] = 0;
        @(negedge clk);
        checks++;
        if (v_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty: v_o=%b, required 0", v_o);
        end
        tick();
    endtask

    task automatic test_illegal();
        enc_cmd_s bad[4];
        cmd_i = mk(eENC_ADDI, 5'd5, 5'd0, 5'd0, 32'd5, 1'b0, 1'b0);
        v_i = 1'b1; yumi_i = 1'b0;
        expq.push_back(32'h00500293);
        tick();
        cmd_i = mk(eENC_ADDI, 5'd5, 5'd0, 5'd0, 32'd4096, 1'b0, 1'b0);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            checks++;
            if (v_o !== 1'b1 || instr_o !== expq[0] || ready_o !== 1'b0 || illegal_o !== 1'b0) begin
                errors++;
                $display("FAIL illegal_hold: v_o=%b instr_o=%h ready_o=%b illegal_o=%b, required 1 %h 0 0",
                         v_o, instr_o, ready_o, illegal_o, expq[0]);
            end
            tick();
        end
        yumi_i = 1'b1;
        @(negedge clk);
        exp_w = expq.pop_front();
        checks++;
        if (v_o !== 1'b1 || instr_o !== exp_w || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL illegal_held_word: v_o=%b instr_o=%h ready_o=%b, required 1 %h 1",
                     v_o, instr_o, ready_o, exp_w);
        end
        tick();
        v_i = 1'b0; yumi_i = 1'b0;
        @(negedge clk);
        checks++;
        if (v_o !== 1'b0 || illegal_o !== 1'b1) begin
            errors++;
            $display("FAIL illegal_addi4096: v_o=%b illegal_o=%b, required 0 1", v_o, illegal_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (illegal_o !== 1'b0 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse_end: illegal_o=%b v_o=%b, required 0 0", illegal_o, v_o);
        end
        tick();
        bad[0] = mk(eENC_LW,  5'd1, 5'd2, 5'd0, -32'sd2049, 1'b0, 1'b0);
        bad[1] = mk(eENC_SW,  5'd0, 5'd2, 5'd3, 32'd2048, 1'b0, 1'b0);
        bad[2] = mk(eENC_FSW, 5'd0, 5'd2, 5'd3, 32'd4096, 1'b0, 1'b0);
        bad[3] = mk(eENC_FLW, 5'd1, 5'd2, 5'd0, 32'h80000000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cmd_i = bad[i]; v_i = 1'b1;
            tick();
            v_i = 1'b0;
            @(negedge clk);
            checks++;
            if (illegal_o !== 1'b1 || v_o !== 1'b0) begin
                errors++;
                $display("FAIL illegal_range[%0d]: illegal_o=%b v_o=%b, required 1 0", i, illegal_o, v_o);
            end
            tick();
            @(negedge clk);
            checks++;
            if (illegal_o !== 1'b0) begin
                errors++;
                $display("FAIL illegal_range_end[%0d]: illegal_o=%b, required 0", i, illegal_o);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_li();
        cmd_i = mk(eENC_LI, 5'd5, 5'd0, 5'd0, 32'h12345678, 1'b0, 1'b0);
        v_i = 1'b1; yumi_i = 1'b0;
        tick();
        v_i = 1'b0;
        @(negedge clk);
        checks++;
        if (v_o !== 1'b1 || instr_o !== 32'h123452B7 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pre: v_o=%b instr_o=%h ready_o=%b, required 1 123452b7 0",
                     v_o, instr_o, ready_o);
        end
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        checks++;
        if (v_o !== 1'b0 || instr_o !== 32'h0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_post: v_o=%b instr_o=%h ready_o=%b, required 0 00000000 1",
                     v_o, instr_o, ready_o);
        end
        for (int s = 0; s < 4; s++) begin
            tick();
            yumi_i = 1'b0;
            @(negedge clk);
            checks++;
            if (v_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid_quiet[%0d]: v_o=%b ready_o=%b, required 0 1", s, v_o, ready_o);
            end
        end
        expq.delete();
        tick();
    endtask

    task automatic test_li_random();
        logic [31:0] imm;
        logic [31:0] hi;
        logic [4:0]  rd;
        bit          acc;
        int          n;
        for (int k = 0; k < 9; k++) begin
            case (k % 3)
                0:       imm = $urandom;
                1:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            rd = 5'(k + 1);
            if ($signed(imm) >= -2048 && $signed(imm) <= 2047) begin
                expq.push_back({imm[11:0], 5'd0, 3'b000, rd, 7'h13});
            end else begin
                hi = (imm + 32'h800) >> 12;
                expq.push_back({hi[19:0], rd, 7'h37});
                if (imm[11:0] != 12'd0) expq.push_back({imm[11:0], rd, 3'b000, rd, 7'h13});
            end
            cmd_i = mk(eENC_LI, rd, 5'd0, 5'd0, imm, 1'b0, 1'b0);
            v_i = 1'b1;
            acc = 1'b0; n = 0;
            while (!acc && n < 20) begin
                yumi_i = v_o;
                @(negedge clk);
                if (v_o) begin
                    exp_w = (expq.size() != 0) ? expq.pop_front() : 32'hx;
                    checks++;
                    if (instr_o !== exp_w) begin
                        errors++;
                        $display("FAIL li_rand[%0d]: instr_o=%h, required %h", k, instr_o, exp_w);
                    end
                end
                acc = ready_o;
                tick();
                n++;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL li_rand_accept[%0d]: ready_o stayed 0 for %0d cycles, required 1", k, n);
            end
        end
        v_i = 1'b0;
        n = 0;
        while (expq.size() != 0 && n < 20) begin
            yumi_i = v_o;
            @(negedge clk);
            if (v_o) begin
                exp_w = expq.pop_front();
                checks++;
                if (instr_o !== exp_w) begin
                    errors++;
                    $display("FAIL li_rand_drain: instr_o=%h, required %h", instr_o, exp_w);
                end
            end
            tick();
            n++;
        end
        yumi_i = 1'b0;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL li_rand_left: %0d words never presented, required 0", expq.size());
            expq.delete();
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_li_two(32'h12345678, 32'h123452B7, 32'h67828293);
        test_li_two(32'h00000800, 32'h000012B7, 32'h80028293);
        test_back_to_back();
        test_illegal();
        test_reset_mid_li();
        test_li_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vanilla_instr_encoder.md
# vanilla_instr_encoder

Encodes high-level instruction commands into 32-bit RV32 `instruction_s` words for the vanilla core. It is the inverse of the core decode stage. It sits between a command source (boot/test sequencer, remote instruction injector) and an instruction sink (icache fill path or fetch-stage injection port). Pseudo-op `LI` expands into a multi-word sequence. All output is registered behind a valid/yumi handshake.

## Interface
Parameters:
- `data_width_p`, default 32: immediate/data width; only 32 is supported.
- `reg_addr_width_p`, default 5: register index width.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `v_i`  in  1  command valid.
- `cmd_i`  in  `enc_cmd_s`  command: `op` (`enc_op_e`), `rd`, `rs1`, `rs2` (5b each), `imm` (32b signed), `aq`, `rl`.
- `ready_o`  out  1  command accepted when `v_i & ready_o`.
- `v_o`  out  1  `instr_o` valid.
- `instr_o`  out  `instruction_s`  encoded instruction word.
- `yumi_i`  in  1  sink consumes `instr_o`; legal only when `v_o`.
- `illegal_o`  out  1  one-cycle pulse: the accepted command was dropped because its immediate is out of range.

## Operation
Supported `enc_op_e` values and their encodings:
- `eENC_ADD`: R-type, funct7=0, funct3=000, op `RV32_OP`.
- `eENC_ADDI`: I-type, funct3=000, op `RV32_OP_IMM`. `imm` must fit signed 12 bits.
- `eENC_LW`: I-type, funct3=010, op `RV32_LOAD`. Same immediate rule.
- `eENC_SW`: S-type, imm[11:5]→[31:25], imm[4:0]→[11:7], funct3=010. Same immediate rule.
- `eENC_FLW` / `eENC_FSW`: as LW/SW with `RV32_LOAD_FP` / `RV32_STORE_FP`.
- `eENC_FADD_S`: funct7=0000000, rm=000, op `RV32_OP_FP`.
- `eENC_AMOADD_W`: funct5=00000, `aq`→[26], `rl`→[25], funct3=010, op `RV32_AMO_OP`.
- `eENC_FENCE`: constant `0x0FF0000F`; all operand fields ignored.
- `eENC_LI`, rd ← imm:
  - If imm fits signed 12 bits: one word, `ADDI rd,x0,imm`.
  - Otherwise: hi = (imm + 0x800) >> 12, computed modulo 2^32. Emit `LUI rd,hi[19:0]`.
  - Then emit `ADDI rd,rd,imm[11:0]`, unless imm[11:0]==0, in which case the LUI alone is the whole sequence.

Range check:
- An out-of-range immediate on ADDI/LW/SW/FLW/FSW means `imm` is not in [-2048, 2047].
- Such a command is still accepted, emits no word, and pulses `illegal_o` the cycle after acceptance.

FSM states:
- `eIdle`: no expansion pending.
- `eLiLo`: LUI is held in the output register and the ADDI low-part is pending.
- Transitions:
  - `eIdle` → `eLiLo` when an LI needing two words is accepted.
  - `eLiLo` → `eIdle` when the LUI is consumed (`yumi_i`); the ADDI is loaded into the output register in that same cycle.

Output register (one entry):
- Loads on accept, or on the `eLiLo` advance.
- Clears `v_o` on `yumi_i` unless it reloads in the same cycle.
- `ready_o = (state==eIdle) & (~v_o | yumi_i)`. This is combinational on `yumi_i`, so sustained throughput is one word per cycle.
- `instr_o` holds stable while `v_o & ~yumi_i`.

## Timing
- Reset values: `v_o`=0, `illegal_o`=0, state=`eIdle`, `instr_o`=0. `ready_o` is 1 the first cycle after reset deasserts.
- Latency: command accepted at cycle N → `v_o` at N+1.
- Two-word LI:
  - LUI is presented at N+1.
  - ADDI is presented the cycle after LUI's `yumi_i`.
  - `ready_o` is 0 from N+1 until the ADDI is loaded.
- Simultaneous `yumi_i` and accept: the old word leaves and the new word appears next cycle with no bubble.
- Stall: `v_o` and `instr_o` hold indefinitely while `yumi_i`=0.
- Reset mid-expansion drops the pending ADDI and the held word. Nothing is emitted after reset.
- An illegal command does not disturb an already-valid held word.

## Structure
- `enc_op_e`, `enc_cmd_s`, funct3/funct7/funct5 constants, and the `0x0FF0000F` fence constant go in `bsg_vanilla_pkg`. Opcodes reuse the existing `RV32_*` defines from `bsg_vanilla_defines.svh`.
- One natural sub-module: `vanilla_instr_encode_comb`, a purely combinational function from (`enc_cmd_s`, lo/hi select) to (`instruction_s`, `two_word`, `illegal`). The parent holds the FSM, the pending-ADDI fields and the output register.

## Test plan
- ADDI rd=5, rs1=0, imm=5 → `instr_o`=0x00500293 at N+1; `yumi_i` held 1 → `ready_o` stays 1.
- LI rd=5, imm=0x12345678 → 0x123452B7, then 0x67828293; `ready_o`=0 until the second word loads.
- LI rd=5, imm=0x800 → 0x000012B7, then 0x80028293.
- LI rd=5, imm=0x1000 → single word 0x000012B7; back-to-back FENCE → 0x0FF0000F on the next cycle with no bubble.
- AMOADD_W rd=1, rs1=3, rs2=2, aq=rl=0 → 0x0021A0AF.
- ADDI imm=4096 → no `v_o`, `illegal_o`=1 one cycle. Separately, assert `reset_i` while in `eLiLo` → `v_o`=0, state `eIdle`, no ADDI emitted afterwards.
